// File: rtl/apb_pkg.sv
// ---------------------------------------------------------------------------
// apb_pkg
// Shared definitions for the command-driven APB requester:
//   - default APB address/data widths
//   - requester FSM state encoding
//   - response record layout {rdata, write, timeout}
//   - width helper for the packed command word stored in the command FIFO
// ---------------------------------------------------------------------------
package apb_pkg;

    localparam int APB_ADDR_W = 32;
    localparam int APB_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_t;

    typedef struct packed {
        logic [APB_DATA_W-1:0] rdata;
        logic                  write;
        logic                  timeout;
    } apb_rsp_t;

    // Command word layout is {write, addr, wdata}, MSB first.
    function automatic int cmd_word_w(input int addr_w, input int data_w);
        return 1 + addr_w + data_w;
    endfunction

endpackage

// File: rtl/apb_cmd_fifo.sv
// ---------------------------------------------------------------------------
// apb_cmd_fifo
// Synchronous FIFO holding packed APB commands.
// Ports:
//   clk, rst   clock, synchronous active-high reset (empties the FIFO)
//   i_push     write request; ignored while full
//   i_wdata    word to write
//   i_pop      read request; ignored while empty
//   o_rdata    head-of-queue word, valid whenever !o_empty
//   o_full     no free entry (registered count, no same-cycle lookahead)
//   o_empty    no valid entry
//   o_count    number of valid entries
// ---------------------------------------------------------------------------
module apb_cmd_fifo #(
    parameter  int WIDTH = 65,
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty,
    output logic [CNT_W-1:0] o_count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic w_push;
    logic w_pop;

    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;

    // Full is judged on the registered count, so a pop on a full FIFO
    // does not open a slot for a push on the same edge.
    assign w_push = i_push && !o_full;
    assign w_pop  = i_pop  && !o_empty;

    // The head is read combinationally: the FSM loads it on the same edge
    // it pops, which keeps push-to-SETUP at a single cycle.
    assign o_rdata = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    // Pointers are log2(DEPTH) bits wide, so they wrap modulo DEPTH.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/apb_cmd_master.sv
// ---------------------------------------------------------------------------
// apb_cmd_master
// Command-driven APB requester. Commands arrive on a valid/ready port, are
// queued in apb_cmd_fifo, executed one at a time as APB SETUP/ACCESS
// transfers (any number of wait states, optional timeout abort), and each
// produces exactly one response on a valid/ready port, in command order.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   cmd_valid/cmd_ready           command handshake
//   cmd_write/cmd_addr/cmd_wdata  command payload
//   rsp_valid/rsp_ready           response handshake
//   rsp_rdata/rsp_write/rsp_timeout  response payload
//   busy                          queued, in-flight or unconsumed work exists
//   paddr/pwdata/pwrite/psel/penable  APB request (all registered)
//   pready/prdata                 APB completion from the bridge
// ---------------------------------------------------------------------------
module apb_cmd_master
    import apb_pkg::*;
#(
    parameter int ADDR_W         = APB_ADDR_W,
    parameter int DATA_W         = APB_DATA_W,
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_write,
    output logic              rsp_timeout,
    output logic              busy,
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata,
    output logic              pwrite,
    output logic              psel,
    output logic              penable,
    input  logic              pready,
    input  logic [DATA_W-1:0] prdata
);

    localparam int CMD_W  = cmd_word_w(ADDR_W, DATA_W);
    localparam int FCNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int CNT_W  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam bit TO_EN  = (TIMEOUT_CYCLES != 0);
    // Counter value seen on the edge of the last permitted wait cycle.
    localparam logic [CNT_W-1:0] TO_LAST =
        CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    apb_state_t        r_state;
    logic [ADDR_W-1:0] r_paddr;
    logic [DATA_W-1:0] r_pwdata;
    logic              r_pwrite;
    logic              r_psel;
    logic              r_penable;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_rsp_valid;
    logic [DATA_W-1:0] r_rsp_rdata;
    logic              r_rsp_write;
    logic              r_rsp_timeout;

    logic [CMD_W-1:0]  w_head;
    logic              w_fifo_full;
    logic              w_fifo_empty;
    logic [FCNT_W-1:0] w_fifo_count;
    logic              w_issue;
    logic              w_done;
    logic              w_abort;

    apb_cmd_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (cmd_valid),
        .i_wdata ({cmd_write, cmd_addr, cmd_wdata}),
        .i_pop   (w_issue),
        .o_rdata (w_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_count)
    );

    // A new transfer only starts when its response slot is guaranteed free
    // by the time it completes, so a pending response is never overwritten.
    assign w_issue = (r_state == IDLE) && !w_fifo_empty && (!r_rsp_valid || rsp_ready);
    assign w_done  = (r_state == ACCESS) && pready;
    assign w_abort = TO_EN && (r_state == ACCESS) && !pready && (r_cnt == TO_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_paddr   <= '0;
            r_pwdata  <= '0;
            r_pwrite  <= 1'b0;
            r_psel    <= 1'b0;
            r_penable <= 1'b0;
            r_cnt     <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_issue) begin
                        r_pwrite  <= w_head[CMD_W-1];
                        r_paddr   <= w_head[DATA_W +: ADDR_W];
                        r_pwdata  <= w_head[DATA_W-1:0];
                        r_psel    <= 1'b1;
                        r_penable <= 1'b0;
                        r_state   <= SETUP;
                    end
                end
                SETUP: begin
                    r_penable <= 1'b1;
                    r_state   <= ACCESS;
                end
                ACCESS: begin
                    if (w_done || w_abort) begin
                        r_psel    <= 1'b0;
                        r_penable <= 1'b0;
                        r_cnt     <= '0;
                        r_state   <= IDLE;
                    end else if (r_cnt != {CNT_W{1'b1}}) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_psel    <= 1'b0;
                    r_penable <= 1'b0;
                    r_state   <= IDLE;
                end
            endcase
        end
    end

    // Single-entry response register; a newly completed transfer takes
    // priority over the consume-clear on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rsp_valid   <= 1'b0;
            r_rsp_rdata   <= '0;
            r_rsp_write   <= 1'b0;
            r_rsp_timeout <= 1'b0;
        end else if (w_done || w_abort) begin
            r_rsp_valid   <= 1'b1;
            r_rsp_rdata   <= (w_done && !r_pwrite) ? prdata : '0;
            r_rsp_write   <= r_pwrite;
            r_rsp_timeout <= w_abort;
        end else if (r_rsp_valid && rsp_ready) begin
            r_rsp_valid <= 1'b0;
        end
    end

    assign cmd_ready   = !w_fifo_full;
    assign busy        = (w_fifo_count != '0) || (r_state != IDLE) || r_rsp_valid;
    assign paddr       = r_paddr;
    assign pwdata      = r_pwdata;
    assign pwrite      = r_pwrite;
    assign psel        = r_psel;
    assign penable     = r_penable;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_rdata   = r_rsp_rdata;
    assign rsp_write   = r_rsp_write;
    assign rsp_timeout = r_rsp_timeout;

endmodule

// File: tb/tb_apb_cmd_master.sv
// ---------------------------------------------------------------------------
// tb_apb_cmd_master
// Directed bench for apb_cmd_master with a small APB slave model
// (programmable wait states, word memory).
// ---------------------------------------------------------------------------
module tb_apb_cmd_master;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_write;
    logic        rsp_timeout;
    logic        busy;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic        pwrite;
    logic        psel;
    logic        penable;
    logic        pready;
    logic [31:0] prdata;

    always #5 clk = ~clk;

    apb_cmd_master #(
        .ADDR_W         (32),
        .DATA_W         (32),
        .FIFO_DEPTH     (4),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_write   (cmd_write),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rdata   (rsp_rdata),
        .rsp_write   (rsp_write),
        .rsp_timeout (rsp_timeout),
        .busy        (busy),
        .paddr       (paddr),
        .pwdata      (pwdata),
        .pwrite      (pwrite),
        .psel        (psel),
        .penable     (penable),
        .pready      (pready),
        .prdata      (prdata)
    );

    // ---------------- APB slave model ----------------
    int          cur_waits = 0;
    int          wcnt;
    logic [31:0] mem [256];

    assign pready = psel && penable && (wcnt >= cur_waits);
    assign prdata = mem[paddr[9:2]];

    always @(posedge clk) begin
        if (rst) wcnt <= 0;
        else if (psel && penable && !pready) wcnt <= wcnt + 1;
        else wcnt <= 0;
        if (rst) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
        end else if (psel && penable && pready && pwrite) begin
            mem[paddr[9:2]] <= pwdata;
        end
    end

    // ---------------- checking ----------------
    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          waits;
        logic [31:0] exp_rdata;
        bit          exp_to;
    } vec_t;

    int   n_vec  = 0;
    int   n_miss = 0;
    vec_t vecs  [8];
    vec_t batch [32];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Offer one command until accepted (bounded); called #1 after an edge.
    task automatic push_cmd(input vec_t v, input string tag);
        bit acc;
        acc       = 1'b0;
        cmd_valid = 1'b1;
        cmd_write = v.wr;
        cmd_addr  = v.addr;
        cmd_wdata = v.wdata;
        for (int c = 0; c < 20 && !acc; c++) begin
            acc = cmd_ready;
            @(posedge clk);
            #1;
        end
        cmd_valid = 1'b0;
        chk({tag, "_accept"}, 32'(acc), 32'd1);
    endtask

    // Run one command in isolation and check its transfer and response.
    task automatic do_cmd(input vec_t v, input string tag);
        int pen_cnt;
        bit moved;
        bit got;
        cur_waits = v.waits;
        rsp_ready = 1'b0;
        push_cmd(v, tag);
        pen_cnt = 0;
        moved   = 1'b0;
        got     = 1'b0;
        for (int c = 0; c < 40 && !got; c++) begin
            if (rsp_valid) begin
                got = 1'b1;
            end else begin
                if (penable) pen_cnt++;
                if (psel && (paddr !== v.addr || pwrite !== v.wr ||
                             (v.wr && pwdata !== v.wdata))) moved = 1'b1;
                @(posedge clk);
                #1;
            end
        end
        chk({tag, "_rsp_seen"},   32'(got),         32'd1);
        chk({tag, "_rdata"},      rsp_rdata,        v.exp_rdata);
        chk({tag, "_write"},      32'(rsp_write),   32'(v.wr));
        chk({tag, "_timeout"},    32'(rsp_timeout), 32'(v.exp_to));
        chk({tag, "_pen_cycles"}, 32'(pen_cnt),     v.exp_to ? 32'(TO) : 32'(v.waits + 1));
        chk({tag, "_stable"},     32'(moved),       32'd0);
        $display("%s: wr=%0d addr=0x%08h waits=%0d -> rdata=0x%08h to=%0d pen=%0d",
                 tag, v.wr, v.addr, v.waits, rsp_rdata, rsp_timeout, pen_cnt);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        chk({tag, "_rsp_clear"}, 32'(rsp_valid), 32'd0);
    endtask

    // Push batch[first..n-1] back-to-back while consuming and checking
    // responses for batch[0..n-1] in order.
    task automatic stream(input int first, input int n, input string tag);
        int np;
        int nr;
        bit acc;
        np        = first;
        nr        = 0;
        rsp_ready = 1'b1;
        for (int c = 0; c < 600 && nr < n; c++) begin
            if (np < n) begin
                cmd_valid = 1'b1;
                cmd_write = batch[np].wr;
                cmd_addr  = batch[np].addr;
                cmd_wdata = batch[np].wdata;
            end else begin
                cmd_valid = 1'b0;
            end
            acc = cmd_valid && cmd_ready;
            if (rsp_valid) begin
                chk($sformatf("%s%0d_rdata", tag, nr),   rsp_rdata,        batch[nr].exp_rdata);
                chk($sformatf("%s%0d_write", tag, nr),   32'(rsp_write),   32'(batch[nr].wr));
                chk($sformatf("%s%0d_timeout", tag, nr), 32'(rsp_timeout), 32'(batch[nr].exp_to));
                $display("%s%0d: wr=%0d addr=0x%08h -> rdata=0x%08h",
                         tag, nr, batch[nr].wr, batch[nr].addr, rsp_rdata);
                nr++;
            end
            @(posedge clk);
            #1;
            if (acc) np++;
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b0;
        chk({tag, "_rsp_count"}, 32'(nr), 32'(n));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int   pushed;
        bit   acc;
        bit   saw_psel;
        bit   saw_pen;
        vec_t v;

        // ---- vector table ----
        vecs[0] = '{wr:1'b1, addr:32'h10, wdata:32'hDEADBEEF, waits:0,  exp_rdata:32'h0,        exp_to:1'b0};
        vecs[1] = '{wr:1'b0, addr:32'h10, wdata:32'h0,        waits:5,  exp_rdata:32'hDEADBEEF, exp_to:1'b0};
        vecs[2] = '{wr:1'b1, addr:32'h20, wdata:32'h12345678, waits:7,  exp_rdata:32'h0,        exp_to:1'b0};
        vecs[3] = '{wr:1'b0, addr:32'h20, wdata:32'h0,        waits:7,  exp_rdata:32'h12345678, exp_to:1'b0};
        vecs[4] = '{wr:1'b1, addr:32'h30, wdata:32'h0000A5A5, waits:8,  exp_rdata:32'h0,        exp_to:1'b1};
        vecs[5] = '{wr:1'b0, addr:32'h30, wdata:32'h0,        waits:0,  exp_rdata:32'h0,        exp_to:1'b0};
        vecs[6] = '{wr:1'b0, addr:32'h10, wdata:32'h0,        waits:99, exp_rdata:32'h0,        exp_to:1'b1};
        vecs[7] = '{wr:1'b0, addr:32'h10, wdata:32'h0,        waits:1,  exp_rdata:32'hDEADBEEF, exp_to:1'b0};

        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = 32'h0;
        cmd_wdata = 32'h0;
        rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_psel",      32'(psel),      32'd0);
        chk("rst_penable",   32'(penable),   32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_paddr",     paddr,          32'd0);
        chk("rst_pwdata",    pwdata,         32'd0);
        chk("rst_busy",      32'(busy),      32'd0);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // ---- latency of a single zero-wait write ----
        cur_waits = 0;
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 32'h40;
        cmd_wdata = 32'hCAFEF00D;
        @(posedge clk);                       // E0: push
        #1;
        cmd_valid = 1'b0;
        chk("lat_e0_psel", 32'(psel), 32'd0);
        chk("lat_e0_busy", 32'(busy), 32'd1);
        @(posedge clk);                       // E1: pop, SETUP
        #1;
        chk("lat_e1_psel",    32'(psel),    32'd1);
        chk("lat_e1_penable", 32'(penable), 32'd0);
        chk("lat_e1_paddr",   paddr,        32'h40);
        chk("lat_e1_pwdata",  pwdata,       32'hCAFEF00D);
        chk("lat_e1_pwrite",  32'(pwrite),  32'd1);
        @(posedge clk);                       // E2: ACCESS
        #1;
        chk("lat_e2_penable", 32'(penable), 32'd1);
        @(posedge clk);                       // E3: completes
        #1;
        chk("lat_e3_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("lat_e3_psel",      32'(psel),      32'd0);
        chk("lat_e3_rsp_write", 32'(rsp_write), 32'd1);
        chk("lat_e3_rsp_rdata", rsp_rdata,      32'd0);
        $display("latency: write 0x40 completed after 3 edges past acceptance");
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;

        // ---- table-driven vectors ----
        for (int i = 0; i < 8; i++) begin
            do_cmd(vecs[i], $sformatf("vec%0d", i));
        end

        // ---- FIFO full / response backpressure ----
        for (int i = 0; i < 3; i++) begin
            batch[2*i]   = '{wr:1'b1, addr:32'h100 + 32'(4*i), wdata:32'h77000000 + 32'(i),
                             waits:0, exp_rdata:32'h0, exp_to:1'b0};
            batch[2*i+1] = '{wr:1'b0, addr:32'h100 + 32'(4*i), wdata:32'h0,
                             waits:0, exp_rdata:32'h77000000 + 32'(i), exp_to:1'b0};
        end
        cur_waits = 0;
        rsp_ready = 1'b0;
        pushed    = 0;
        for (int c = 0; c < 20 && pushed < 5; c++) begin
            cmd_valid = 1'b1;
            cmd_write = batch[pushed].wr;
            cmd_addr  = batch[pushed].addr;
            cmd_wdata = batch[pushed].wdata;
            acc       = cmd_ready;
            @(posedge clk);
            #1;
            if (acc) pushed++;
        end
        cmd_valid = 1'b0;
        chk("bp_pushed", 32'(pushed), 32'd5);
        saw_psel = 1'b0;
        for (int c = 0; c < 6; c++) begin
            if (psel) saw_psel = 1'b1;
            @(posedge clk);
            #1;
        end
        chk("bp_no_issue",  32'(saw_psel),  32'd0);
        chk("bp_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("bp_busy",      32'(busy),      32'd1);
        stream(5, 6, "bp");

        // ---- reset during a wait state ----
        cur_waits = 99;
        v = '{wr:1'b0, addr:32'h10, wdata:32'h0, waits:99, exp_rdata:32'h0, exp_to:1'b0};
        push_cmd(v, "rs_first");
        v = '{wr:1'b1, addr:32'h60, wdata:32'h11111111, waits:99, exp_rdata:32'h0, exp_to:1'b0};
        push_cmd(v, "rs_second");
        saw_pen = 1'b0;
        for (int c = 0; c < 10 && !saw_pen; c++) begin
            if (penable) saw_pen = 1'b1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        chk("rs_in_access", 32'(saw_pen), 32'd1);
        rsp_ready = 1'b1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rs_psel",      32'(psel),      32'd0);
        chk("rs_penable",   32'(penable),   32'd0);
        chk("rs_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rs_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rs_busy",      32'(busy),      32'd0);
        saw_psel = 1'b0;
        for (int c = 0; c < 4; c++) begin
            if (psel || rsp_valid) saw_psel = 1'b1;
            @(posedge clk);
            #1;
        end
        chk("rs_quiet", 32'(saw_psel), 32'd0);
        rsp_ready = 1'b0;
        v = '{wr:1'b1, addr:32'h50, wdata:32'h0BADF00D, waits:2, exp_rdata:32'h0, exp_to:1'b0};
        do_cmd(v, "rs_wr");
        v = '{wr:1'b0, addr:32'h50, wdata:32'h0, waits:3, exp_rdata:32'h0BADF00D, exp_to:1'b0};
        do_cmd(v, "rs_rd");

        // ---- back-to-back write/read pairs ----
        for (int i = 0; i < 16; i++) begin
            batch[2*i]   = '{wr:1'b1, addr:32'h200 + 32'(4*i),
                             wdata:32'hA5000000 ^ (32'(i) * 32'h00010203),
                             waits:0, exp_rdata:32'h0, exp_to:1'b0};
            batch[2*i+1] = '{wr:1'b0, addr:32'h200 + 32'(4*i), wdata:32'h0, waits:0,
                             exp_rdata:32'hA5000000 ^ (32'(i) * 32'h00010203), exp_to:1'b0};
        end
        cur_waits = 1;
        stream(0, 32, "b2b");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
